lc3_regfile_sb: RTL and testbench
=================================

# lc3_regfile_sb

Parametrised general-purpose register file for the pipelined LC-3 datapath. It generalises the single-write/two-read 8x16 file to configurable width, depth and read-port count. It adds synchronous reset, an optional same-cycle write-to-read bypass, a per-register busy scoreboard for in-flight writes, and the architectural NZP condition-code register updated on write-back. It sits between decode (read/reserve) and write-back (write/clear) and replaces the unpipelined file.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers (power of two, >= 2); AW = $clog2(DEPTH)
- NRD, 2, number of independent read ports (>= 1)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored value only
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- sr  in  NRD*AW  flattened read addresses; port i = sr[i*AW +: AW]
- sr_out  out  NRD*WIDTH  flattened read data; port i = sr_out[i*WIDTH +: WIDTH]
- sr_busy  out  NRD  port i source has an outstanding reserved write
- ld_reg  in  1  write enable (write-back)
- dr  in  AW  write address
- wdata  in  WIDTH  write data (global bus)
- ld_cc  in  1  update NZP from wdata; independent of ld_reg
- rsv  in  1  reserve (mark busy) register rsv_dr
- rsv_dr  in  AW  register to reserve
- nzp  out  3  condition codes {N,Z,P}
- busy_vec  out  DEPTH  raw scoreboard state, bit k = register k busy

## Operation
- Storage: DEPTH x WIDTH registers, busy[DEPTH], nzp[2:0].
- Reset (rst_n=0 at posedge): all registers = 0, busy = 0, nzp = 3'b010 (Z). Reset overrides ld_reg, ld_cc and rsv in the same cycle. Mid-operation reset discards all pending reservations.
- Read (combinational): sr_out[i] = regs[sr[i]], unless BYPASS=1, ld_reg=1 and dr==sr[i]; in that case sr_out[i] = wdata.
- Write: ld_reg=1 at posedge -> regs[dr] <= wdata.
- Busy, next state per register k:
  - set if rsv=1 and rsv_dr==k;
  - else clear if ld_reg=1 and dr==k;
  - else hold.
  - When reserve and write target the same register in one cycle, reserve wins: the new producer is pending.
  - Reserving an already busy register leaves it busy (single bit, no count). Issue logic stalls on busy, so double reservation is an upstream error.
  - A write to a non-busy register is legal and leaves busy=0.
- sr_busy[i] = busy[sr[i]] & ~(BYPASS & ld_reg & dr==sr[i]). With BYPASS=0, a register being written this cycle still reads busy until the next cycle.
- NZP: ld_cc=1 -> nzp <= wdata[WIDTH-1] ? 100 : (wdata==0 ? 010 : 001). Exactly one bit of nzp is set at all times.
- busy_vec = busy (registered, no bypass).

## Timing
- Read and bypass latency: 0 cycles (combinational from sr, dr, ld_reg, wdata).
- Write visible in stored state 1 cycle after the ld_reg posedge. With BYPASS=1 it is visible in the same cycle.
- Reservation visible on sr_busy/busy_vec the cycle after the rsv posedge.
- Clear via write: sr_busy drops the same cycle if BYPASS=1, and busy_vec drops the next cycle.
- nzp changes the cycle after the ld_cc posedge, with no bypass.
- All outputs are defined (0 data, nzp=010, busy=0) from the first posedge with rst_n=0.

## Structure
- Shared package lc3_pkg: WIDTH_DEF=16, DEPTH_DEF=8, NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, and function nzp_of(data) returning the 3-bit code.
- One sub-module is natural: lc3_sb_bank, which holds the busy bit array with its set/clear priority. The register array, read muxes and NZP register stay in the top module.

## Test plan
- Reset: write R3=16'h1234, reserve R5, ld_cc with 16'h8000, then assert rst_n=0 for one posedge -> all sr_out=0, busy_vec=0, nzp=010.
- Write/read with BYPASS=1: ld_reg, dr=2, wdata=16'hBEEF, sr port0=2 in the same cycle -> sr_out[0]=BEEF that cycle. The next cycle, with ld_reg=0 -> still BEEF. With BYPASS=0, the same-cycle read returns the old value 0.
- Scoreboard: rsv R4 -> next cycle busy_vec[4]=1 and sr_busy=1 for sr=4. Write R4=7 -> sr_busy=0 that cycle (BYPASS=1) and busy_vec[4]=0 the next cycle.
- Simultaneous: rsv_dr=6 and ld_reg dr=6 in one cycle, with R6 previously busy -> R6 updated and busy_vec[6] remains 1.
- NZP: ld_cc with wdata 16'hFFFF -> 100; 16'h0000 -> 010; 16'h0001 -> 001. Also ld_cc=1 with ld_reg=0 -> nzp updates and no register changes.
- Parameter sweep: WIDTH=32, DEPTH=16, NRD=3. Write R15 and read it on all three ports -> matching data. R0..R14 unaffected.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared constants and NZP helper for the LC-3 register file
//
// Purpose: default geometry, condition-code encodings and the NZP
//          derivation used on write-back.
// Ports:   none (package).

package lc3_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 8;

   localparam logic [2:0] NZP_N = 3'b100;
   localparam logic [2:0] NZP_Z = 3'b010;
   localparam logic [2:0] NZP_P = 3'b001;

   // Callers sign-extend their data to this width, so one helper serves
   // every register width up to 64 bits.
   localparam int NZP_DATA_W = 64;

   function automatic logic [2:0] nzp_of(input logic [NZP_DATA_W-1:0] data);
      if (data[NZP_DATA_W-1]) begin
         return NZP_N;
      end else if (data == '0) begin
         return NZP_Z;
      end else begin
         return NZP_P;
      end
   endfunction

endpackage

// File: rtl/lc3_sb_bank.sv
// rtl/lc3_sb_bank.sv - per-register busy scoreboard for in-flight writes
//
// Purpose: one busy bit per architectural register. Decode reserves the
//          destination, write-back clears it.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   rsv, rsv_dr reserve request and register index
//   clr, clr_dr write-back clear request and register index
//   busy        registered busy bits, bit k = register k

module lc3_sb_bank #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rsv,
   input  logic [AW-1:0]    rsv_dr,
   input  logic             clr,
   input  logic [AW-1:0]    clr_dr,
   output logic [DEPTH-1:0] busy
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            // Reserve beats clear: a same-cycle write-back retires the old
            // producer while the newly issued producer is still pending.
            if (rsv && (rsv_dr == AW'(k))) begin
               busy[k] <= 1'b1;
            end else if (clr && (clr_dr == AW'(k))) begin
               busy[k] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/lc3_regfile_sb.sv
// rtl/lc3_regfile_sb.sv - parametrised LC-3 register file with scoreboard and NZP
//
// Purpose: DEPTH x WIDTH general-purpose registers with NRD combinational
//          read ports, optional write-to-read bypass, busy scoreboard and
//          the architectural NZP condition-code register.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   sr / sr_out     flattened read addresses / read data, port i at slice i
//   sr_busy         per read port: source has an outstanding reserved write
//   ld_reg, dr      write enable and address
//   wdata           write data, also the source of NZP
//   ld_cc           update NZP from wdata
//   rsv, rsv_dr     reserve (mark busy) a destination register
//   nzp             condition codes {N,Z,P}
//   busy_vec        raw registered scoreboard state

module lc3_regfile_sb
   import lc3_pkg::*;
#(
   parameter  int WIDTH  = WIDTH_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int NRD    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    sr,
   output logic [NRD*WIDTH-1:0] sr_out,
   output logic [NRD-1:0]       sr_busy,
   input  logic                 ld_reg,
   input  logic [AW-1:0]        dr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 ld_cc,
   input  logic                 rsv,
   input  logic [AW-1:0]        rsv_dr,
   output logic [2:0]           nzp,
   output logic [DEPTH-1:0]     busy_vec
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs[k] <= '0;
         end
      end else if (ld_reg) begin
         regs[dr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nzp <= NZP_Z;
      end else if (ld_cc) begin
         nzp <= nzp_of(NZP_DATA_W'($signed(wdata)));
      end
   end

   lc3_sb_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sb_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .rsv    (rsv),
      .rsv_dr (rsv_dr),
      .clr    (ld_reg),
      .clr_dr (dr),
      .busy   (busy)
   );

   assign busy_vec = busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;

      assign addr = sr[i*AW +: AW];
      // A matching write this cycle both supplies the data and retires the
      // pending producer, so the port sees it as not busy.
      assign hit  = (BYPASS != 0) && ld_reg && (dr == addr);

      assign sr_out[i*WIDTH +: WIDTH] = hit ? wdata : regs[addr];
      assign sr_busy[i]               = busy[addr] & ~hit;
   end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb/tb_lc3_regfile_sb.sv - scoreboard testbench for lc3_regfile_sb

module tb_lc3_regfile_sb;
   import lc3_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [5:0]  sr;
   logic        ld_reg;
   logic [2:0]  dr;
   logic [15:0] wdata;
   logic        ld_cc;
   logic        rsv;
   logic [2:0]  rsv_dr;

   logic [31:0] a_sr_out, b_sr_out;
   logic [1:0]  a_sr_busy, b_sr_busy;
   logic [2:0]  a_nzp, b_nzp;
   logic [7:0]  a_busy_vec, b_busy_vec;

   logic [11:0] c_sr;
   logic        c_ld_reg;
   logic [3:0]  c_dr;
   logic [31:0] c_wdata;
   logic        c_ld_cc;
   logic        c_rsv;
   logic [3:0]  c_rsv_dr;
   logic [95:0] c_sr_out;
   logic [2:0]  c_sr_busy;
   logic [2:0]  c_nzp;
   logic [15:0] c_busy_vec;

   lc3_regfile_sb #(.WIDTH(16), .DEPTH(8), .NRD(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .sr(sr), .sr_out(a_sr_out), .sr_busy(a_sr_busy),
      .ld_reg(ld_reg), .dr(dr), .wdata(wdata), .ld_cc(ld_cc), .rsv(rsv),
      .rsv_dr(rsv_dr), .nzp(a_nzp), .busy_vec(a_busy_vec)
   );

   lc3_regfile_sb #(.WIDTH(16), .DEPTH(8), .NRD(2), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .sr(sr), .sr_out(b_sr_out), .sr_busy(b_sr_busy),
      .ld_reg(ld_reg), .dr(dr), .wdata(wdata), .ld_cc(ld_cc), .rsv(rsv),
      .rsv_dr(rsv_dr), .nzp(b_nzp), .busy_vec(b_busy_vec)
   );

   lc3_regfile_sb #(.WIDTH(32), .DEPTH(16), .NRD(3), .BYPASS(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .sr(c_sr), .sr_out(c_sr_out), .sr_busy(c_sr_busy),
      .ld_reg(c_ld_reg), .dr(c_dr), .wdata(c_wdata), .ld_cc(c_ld_cc), .rsv(c_rsv),
      .rsv_dr(c_rsv_dr), .nzp(c_nzp), .busy_vec(c_busy_vec)
   );

   // Observation selectors
   localparam int A_RD = 0, A_SB = 1, A_BV = 2, A_CC = 3;
   localparam int B_RD = 4, B_SB = 5, B_BV = 6, B_CC = 7;
   localparam int C_RD = 8, C_SB = 9, C_BV = 10, C_CC = 11;

   typedef struct {
      string       tag;
      int          sel;
      int          port;
      logic [31:0] exp;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] observe(input int sel, input int port);
      case (sel)
         A_RD:    return 32'(a_sr_out[port*16 +: 16]);
         A_SB:    return 32'(a_sr_busy[port]);
         A_BV:    return 32'(a_busy_vec);
         A_CC:    return 32'(a_nzp);
         B_RD:    return 32'(b_sr_out[port*16 +: 16]);
         B_SB:    return 32'(b_sr_busy[port]);
         B_BV:    return 32'(b_busy_vec);
         B_CC:    return 32'(b_nzp);
         C_RD:    return c_sr_out[port*32 +: 32];
         C_SB:    return 32'(c_sr_busy[port]);
         C_BV:    return 32'(c_busy_vec);
         C_CC:    return 32'(c_nzp);
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // delay 0: combinational result of the inputs now driven;
   // delay 1: registered result visible after the next posedge.
   task automatic expect_at(input string tag, input int sel, input int port,
                            input logic [31:0] exp, input int delay);
      exp_t e;
      e.tag  = tag;
      e.sel  = sel;
      e.port = port;
      e.exp  = exp;
      e.due  = cyc + delay;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t keep[$];
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.due <= cyc) check_eq(e.tag, observe(e.sel, e.port), e.exp);
         else keep.push_back(e);
      end
      sb_q = keep;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      drain();
   endtask

   task automatic settle();
      #1;
      drain();
   endtask

   task automatic idle();
      ld_reg   = 1'b0;
      ld_cc    = 1'b0;
      rsv      = 1'b0;
      c_ld_reg = 1'b0;
      c_ld_cc  = 1'b0;
      c_rsv    = 1'b0;
   endtask

   task automatic set_rd(input logic [2:0] p0, input logic [2:0] p1);
      sr = {p1, p0};
   endtask

   initial begin
      rst_n = 1'b0;
      sr = '0; dr = '0; wdata = '0; rsv_dr = '0;
      c_sr = '0; c_dr = '0; c_wdata = '0; c_rsv_dr = '0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      expect_at("rst_rd0", A_RD, 0, 32'h0, 0);
      expect_at("rst_bv", A_BV, 0, 32'h0, 0);
      expect_at("rst_nzp", A_CC, 0, 32'(NZP_Z), 0);
      expect_at("rst_c_nzp", C_CC, 0, 32'(NZP_Z), 0);
      expect_at("rst_c_bv", C_BV, 0, 32'h0, 0);
      settle();

      // Build up state, then reset it away with all controls active
      ld_reg = 1'b1; dr = 3'd3; wdata = 16'h1234; rsv = 1'b1; rsv_dr = 3'd5;
      tick();
      idle();
      ld_cc = 1'b1; wdata = 16'h8000; set_rd(3'd3, 3'd5);
      expect_at("pre_rd_r3", A_RD, 0, 32'h1234, 0);
      expect_at("pre_busy_r5", A_SB, 1, 32'h1, 0);
      expect_at("pre_nzp", A_CC, 0, 32'(NZP_N), 1);
      expect_at("pre_bv", A_BV, 0, 32'h20, 1);
      settle();
      tick();
      rst_n = 1'b0;
      ld_reg = 1'b1; dr = 3'd3; wdata = 16'h5555; rsv = 1'b1; rsv_dr = 3'd1; ld_cc = 1'b1;
      tick();
      rst_n = 1'b1;
      idle();
      expect_at("rst2_rd_r3", A_RD, 0, 32'h0, 0);
      expect_at("rst2_bv", A_BV, 0, 32'h0, 0);
      expect_at("rst2_nzp", A_CC, 0, 32'(NZP_Z), 0);
      expect_at("rst2_sb_r5", A_SB, 1, 32'h0, 0);
      settle();

      // Write with same-cycle read: bypass vs stored value
      set_rd(3'd2, 3'd0);
      ld_reg = 1'b1; dr = 3'd2; wdata = 16'hBEEF;
      expect_at("byp_rd", A_RD, 0, 32'hBEEF, 0);
      expect_at("nobyp_rd", B_RD, 0, 32'h0, 0);
      expect_at("byp_other", A_RD, 1, 32'h0, 0);
      settle();
      tick();
      ld_reg = 1'b0;
      expect_at("stored_a", A_RD, 0, 32'hBEEF, 0);
      expect_at("stored_b", B_RD, 0, 32'hBEEF, 0);
      settle();

      // Reserve R4, then clear it with a write
      set_rd(3'd4, 3'd4);
      rsv = 1'b1; rsv_dr = 3'd4;
      expect_at("rsv_same_cyc", A_SB, 0, 32'h0, 0);
      expect_at("rsv_bv", A_BV, 0, 32'h10, 1);
      expect_at("rsv_sb", A_SB, 0, 32'h1, 1);
      settle();
      tick();
      rsv = 1'b0;
      ld_reg = 1'b1; dr = 3'd4; wdata = 16'h0007;
      expect_at("clr_sb_byp", A_SB, 0, 32'h0, 0);
      expect_at("clr_sb_nobyp", B_SB, 0, 32'h1, 0);
      expect_at("clr_rd", A_RD, 0, 32'h7, 0);
      expect_at("clr_bv_a", A_BV, 0, 32'h0, 1);
      expect_at("clr_bv_b", B_BV, 0, 32'h0, 1);
      settle();
      tick();
      ld_reg = 1'b0;
      expect_at("clr_sb_b_next", B_SB, 0, 32'h0, 0);
      settle();

      // Write to a non-busy register leaves it non-busy
      ld_reg = 1'b1; dr = 3'd1; wdata = 16'h0011; rsv = 1'b1; rsv_dr = 3'd7;
      expect_at("nb_write_bv", A_BV, 0, 32'h80, 1);
      settle();
      tick();
      idle();

      // Reserve and write the same busy register in one cycle
      rsv = 1'b1; rsv_dr = 3'd6;
      tick();
      rsv = 1'b1; rsv_dr = 3'd6; ld_reg = 1'b1; dr = 3'd6; wdata = 16'h0666;
      expect_at("sim_bv", A_BV, 0, 32'hC0, 1);
      settle();
      tick();
      idle();
      set_rd(3'd6, 3'd6);
      expect_at("sim_rd", A_RD, 0, 32'h0666, 0);
      expect_at("sim_sb_a", A_SB, 1, 32'h1, 0);
      expect_at("sim_sb_b", B_SB, 0, 32'h1, 0);
      settle();
      ld_reg = 1'b1; dr = 3'd6;
      tick();
      dr = 3'd7; wdata = 16'h0077;
      tick();
      idle();
      expect_at("cleanup_bv", A_BV, 0, 32'h0, 0);
      settle();

      // Condition codes, ld_cc alone must not write a register
      set_rd(3'd2, 3'd1);
      dr = 3'd2;
      ld_cc = 1'b1; wdata = 16'hFFFF;
      expect_at("nzp_neg", A_CC, 0, 32'(NZP_N), 1);
      settle();
      tick();
      wdata = 16'h0000;
      expect_at("nzp_zero", A_CC, 0, 32'(NZP_Z), 1);
      expect_at("nzp_zero_b", B_CC, 0, 32'(NZP_Z), 1);
      settle();
      tick();
      wdata = 16'h0001;
      expect_at("nzp_pos", A_CC, 0, 32'(NZP_P), 1);
      expect_at("cc_no_byp", A_RD, 0, 32'hBEEF, 0);
      settle();
      tick();
      ld_cc = 1'b0; wdata = 16'h8000;
      expect_at("nzp_hold", A_CC, 0, 32'(NZP_P), 1);
      expect_at("cc_no_write", A_RD, 0, 32'hBEEF, 1);
      expect_at("cc_no_write_r1", A_RD, 1, 32'h0011, 1);
      settle();
      tick();

      // Wide configuration: 32-bit, 16 registers, 3 read ports
      c_ld_reg = 1'b1; c_dr = 4'd15; c_wdata = 32'hDEADBEEF; c_ld_cc = 1'b1;
      expect_at("c_nzp", C_CC, 0, 32'(NZP_N), 1);
      settle();
      tick();
      idle();
      c_sr = {3{4'd15}};
      for (int p = 0; p < 3; p++) expect_at($sformatf("c_r15_p%0d", p), C_RD, p, 32'hDEADBEEF, 0);
      expect_at("c_sb", C_SB, 2, 32'h0, 0);
      expect_at("c_bv", C_BV, 0, 32'h0, 0);
      settle();
      for (int k = 0; k < 15; k++) begin
         c_sr = {3{4'(k)}};
         expect_at($sformatf("c_r%0d", k), C_RD, k % 3, 32'h0, 0);
         settle();
      end

      tick();
      check_eq("leftover", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
